id_exe_pipe: RTL
================

Name: id_exe_pipe

Overview:
- Parametrised successor of the ID/EX pipeline register. Replaces the global stall-vector interface with a per-stage valid/ready handshake.
- Adds an optional 2-entry skid buffer, so ID never loses an instruction when EXE back-pressures.
- Provides flush-to-NOP and load-use hazard sideband (inst_is_load_o, rd_o) to ID.
- Sits between the ID decode/operand-read logic and the EXE stage.

Parameters:
- DATA_WIDTH, 32, instruction and operand width.
- ADDR_WIDTH, 32, instruction address width.
- RADDR_WIDTH, 5, register-file address width.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single entry with combinational ready.
- NOP_INST, 32'h00000013, encoding driven on inst_o when the stage holds no valid instruction.
- LOAD_OPCODE, 7'b0000011, opcode (inst[6:0]) that marks a load.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  ID presents a valid instruction.
- in_ready_o  out  1  stage can accept an instruction this cycle.
- op1_i  in  DATA_WIDTH  operand 1.
- op2_i  in  DATA_WIDTH  operand 2.
- reg_we_i  in  1  register write enable.
- reg_waddr_i  in  RADDR_WIDTH  destination register.
- inst_i  in  DATA_WIDTH  instruction word.
- inst_addr_i  in  ADDR_WIDTH  instruction address.
- flush_i  in  1  jump/branch flush from ctrl.
- out_valid_o  out  1  EXE payload valid.
- out_ready_i  in  1  EXE accepts the payload.
- op1_o  out  DATA_WIDTH  operand 1 to EXE.
- op2_o  out  DATA_WIDTH  operand 2 to EXE.
- reg_we_o  out  1  register write enable to EXE.
- reg_waddr_o  out  RADDR_WIDTH  destination register to EXE.
- inst_o  out  DATA_WIDTH  instruction word to EXE.
- inst_addr_o  out  ADDR_WIDTH  instruction address to EXE.
- inst_is_load_o  out  1  valid head entry is a load (to ID hazard unit).
- rd_o  out  RADDR_WIDTH  rd field of the valid head entry (to ID).
- occupancy_o  out  2  number of valid entries, 0..2.

Behaviour:
- Reset (rst_i=1, asynchronous): both entries invalid; out_valid_o=0; inst_o=NOP_INST; op1_o/op2_o=0; reg_we_o=0; reg_waddr_o=0; rd_o=0; inst_is_load_o=0; inst_addr_o=0; occupancy_o=0; in_ready_o=1 after reset (SKID_EN=1).
- Handshake:
  - Accept = in_valid_i & in_ready_o & ~flush_i.
  - Drain = out_valid_o & out_ready_i.
  - Payload captured at the rising edge; latency 1 cycle, in_valid_i to out_valid_o.
- Storage: head register (drives outputs) and skid register (SKID_EN=1 only).
- Head/skid update rules:
  - Head empty, Accept: head <= input.
  - Head valid, Drain, skid empty, Accept: head <= input (back-to-back throughput 1/cycle).
  - Head valid, Drain, skid valid: head <= skid; skid <= input if Accept, else skid empties.
  - Head valid, no Drain, Accept: skid <= input.
- in_ready_o (SKID_EN=1): registered, equal to ~skid_valid after the edge; never depends combinationally on out_ready_i.
- in_ready_o (SKID_EN=0): ~out_valid_o | out_ready_i, combinational; no skid register.
- Payload stability: while out_valid_o=1 and out_ready_i=0, all outputs hold stable.
- Empty head (bubble):
  - Data fields forced to NOP values: inst_o=NOP_INST, ops=0, reg_we_o=0, reg_waddr_o=0, rd_o=0, inst_is_load_o=0.
  - inst_addr_o holds its last value.
- Hazard sideband:
  - inst_is_load_o = out_valid_o & (inst_o[6:0]==LOAD_OPCODE).
  - rd_o = inst_o[11:7] when valid, else 0.
- Flush (flush_i=1 at edge):
  - Both entries invalidated; any same-cycle Accept is discarded; outputs go to NOP values.
  - inst_addr_o holds; in_ready_o=1 next cycle.
  - Flush has priority over Drain and Accept.
- Occupancy:
  - occupancy_o = head_valid + skid_valid.
  - occupancy_o never exceeds 2; never exceeds 1 when SKID_EN=0.
- Protocol violation: in_valid_i while in_ready_o=0 is ignored; ID must hold its payload.

Test Plan:
- Reset mid-stream: assert rst_i asynchronously with occupancy 2 -> same cycle out_valid_o=0, inst_o=32'h00000013, occupancy_o=0; in_ready_o=1 after release.
- Streaming: out_ready_i=1, issue addi x5 (inst_addr 0x100), then lw x6 (0x104) -> out_valid_o on consecutive cycles; second cycle inst_is_load_o=1, rd_o=6; throughput 1/cycle.
- Back-pressure: out_ready_i=0, issue two instructions at 0x200 and 0x204 -> occupancy_o=2, in_ready_o=0, outputs frozen on 0x200. Release out_ready_i -> 0x200 then 0x204 in order, no loss or duplication.
- Flush with full buffer: occupancy 2 plus in_valid_i and flush_i together -> next cycle occupancy_o=0, reg_we_o=0, inst_o=NOP_INST, inst_addr_o unchanged, in_ready_o=1.
- Bubble: in_valid_i=0 for one cycle between lw x7 and add -> that cycle out_valid_o=0, inst_is_load_o=0, rd_o=0, reg_we_o=0.
- SKID_EN=0 build: out_ready_i=0, second in_valid_i -> in_ready_o=0 combinationally, occupancy_o stays at 1; raising out_ready_i raises in_ready_o the same cycle.

Source files
------------

// File: rtl/id_exe_pipe.sv
// -----------------------------------------------------------------------------
// id_exe_pipe
//
// ID/EX pipeline stage with a valid/ready handshake on both sides. It holds a
// head entry that drives the EXE-facing outputs. With SKID_EN=1 it also holds
// a skid entry, so ID can still hand over one instruction while EXE is
// back-pressuring.
//
// Handshake (both sides): a transfer happens at a rising edge when valid and
// ready are both high in the cycle before that edge. The producer must hold
// its payload stable while valid=1 and ready=0. An input transfer (Accept)
// is additionally suppressed by flush_i.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   in_valid_i/in_ready_o  ID-side handshake
//   op1_i, op2_i, reg_we_i, reg_waddr_i, inst_i, inst_addr_i  ID payload
//   flush_i             jump/branch flush; empties the stage, beats Accept/Drain
//   out_valid_o/out_ready_i  EXE-side handshake
//   op1_o .. inst_addr_o     EXE payload (NOP values when the head is empty;
//                            inst_addr_o keeps its last value instead)
//   inst_is_load_o, rd_o  load-use hazard sideband to ID
//   occupancy_o           number of valid entries (0..2)
// -----------------------------------------------------------------------------
module id_exe_pipe #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    RADDR_WIDTH = 5,
    parameter bit                    SKID_EN     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] NOP_INST    = 32'h00000013,
    parameter logic [6:0]            LOAD_OPCODE = 7'b0000011
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_WIDTH-1:0]  op1_i,
    input  logic [DATA_WIDTH-1:0]  op2_i,
    input  logic                   reg_we_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic [DATA_WIDTH-1:0]  inst_i,
    input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  op1_o,
    output logic [DATA_WIDTH-1:0]  op2_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic [DATA_WIDTH-1:0]  inst_o,
    output logic [ADDR_WIDTH-1:0]  inst_addr_o,
    output logic                   inst_is_load_o,
    output logic [RADDR_WIDTH-1:0] rd_o,
    output logic [1:0]             occupancy_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  op1;
        logic [DATA_WIDTH-1:0]  op2;
        logic                   we;
        logic [RADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0]  inst;
        logic [ADDR_WIDTH-1:0]  addr;
    } entry_t;

    entry_t head;
    entry_t skid;
    entry_t in_entry;
    logic   head_valid;
    logic   skid_valid;
    logic   accept;
    logic   drain;

    assign in_entry = '{op1: op1_i, op2: op2_i, we: reg_we_i, waddr: reg_waddr_i,
                        inst: inst_i, addr: inst_addr_i};

    // With the skid buffer, ready is just the inverted skid flag: a flop
    // output, so there is no combinational path from out_ready_i to ID.
    generate
        if (SKID_EN) begin : g_skid_ready
            assign in_ready_o = ~skid_valid;
        end else begin : g_pass_ready
            assign in_ready_o = ~head_valid | out_ready_i;
        end
    endgenerate

    assign accept = in_valid_i & in_ready_o & ~flush_i;
    assign drain  = head_valid & out_ready_i;

    // The skid entry only fills while the head is stalled, and it always
    // moves into the head at the next drain, so the skid is never valid
    // while the head is empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head       <= '0;
            skid       <= '0;
        end else if (flush_i) begin
            // Payload registers keep their contents so inst_addr_o holds.
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!head_valid) begin
            if (accept) begin
                head_valid <= 1'b1;
                head       <= in_entry;
            end
        end else if (drain) begin
            if (skid_valid) begin
                head       <= skid;
                skid_valid <= accept;
                if (accept) begin
                    skid <= in_entry;
                end
            end else begin
                head_valid <= accept;
                if (accept) begin
                    head <= in_entry;
                end
            end
        end else if (accept && SKID_EN) begin
            skid_valid <= 1'b1;
            skid       <= in_entry;
        end
    end

    // Bubbles present as a NOP so EXE never commits stale write enables.
    assign out_valid_o    = head_valid;
    assign op1_o          = head_valid ? head.op1   : '0;
    assign op2_o          = head_valid ? head.op2   : '0;
    assign reg_we_o       = head_valid & head.we;
    assign reg_waddr_o    = head_valid ? head.waddr : '0;
    assign inst_o         = head_valid ? head.inst  : NOP_INST;
    assign inst_addr_o    = head.addr;
    assign inst_is_load_o = head_valid & (head.inst[6:0] == LOAD_OPCODE);
    assign rd_o           = head_valid ? head.inst[7 +: RADDR_WIDTH] : '0;
    assign occupancy_o    = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule
